program_memory: RTL and testbench
=================================

Name: program_memory

Overview:
- 16x8 unified program/data memory on the CPU side of the `read`/`write`/`address`/`memoryIn`/`memoryOut` bus; the CPU fetches instructions and operands from it.
- Adds a byte-stream loader port that fills memory before execution.
- Holds the CPU in clear (`cpu_clr`) while loading, then releases it so fetch starts cleanly from PC=0.

Parameters:
- ADDR_W, 4, address width; matches the CPU `address` bus.
- DATA_W, 8, data width; matches `memoryIn`/`memoryOut`.
- DEPTH, 16, number of words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; asynchronous, active-low.
- read  in  1  CPU read strobe.
- write  in  1  CPU write strobe.
- address  in  ADDR_W  CPU word address.
- memoryIn  in  DATA_W  CPU write data.
- memoryOut  out  DATA_W  read data to CPU.
- ld_start  in  1  pulse: begin a load session.
- ld_valid  in  1  loader byte valid.
- ld_data  in  DATA_W  loader byte.
- ld_last  in  1  qualifies final byte, with ld_valid.
- ld_ready  out  1  memory accepts loader byte.
- cpu_clr  out  1  active-high clear to CPU; connects to CPU clr.
- load_done  out  1  high while CPU runs from loaded image.

Behaviour:
- Reset (clr=0, async):
  - state=IDLE, all DEPTH words=0, load pointer=0.
  - ld_ready=0, cpu_clr=1, load_done=0, memoryOut=0.
- States: IDLE, LOAD, RELEASE, RUN.
- IDLE:
  - cpu_clr=1, ld_ready=0.
  - ld_start=1 -> LOAD with pointer=0.
- LOAD:
  - cpu_clr=1, ld_ready=1.
  - Each cycle with ld_valid & ld_ready: mem[pointer] <= ld_data; pointer++.
  - Exit to RELEASE on acceptance of a byte with ld_last=1, or of the byte at pointer=DEPTH-1, whichever comes first.
  - Words not written in this session keep prior contents.
  - ld_start ignored in LOAD. Pointer never wraps.
- RELEASE:
  - Exactly 1 cycle; cpu_clr=1, ld_ready=0.
  - Guarantees the CPU sees clr on at least one edge after the last write.
  - Then -> RUN.
- RUN:
  - cpu_clr=0, load_done=1, ld_ready=0.
  - Write: write=1 -> mem[address] <= memoryIn at the clock edge.
  - Read: combinational, memoryOut = read ? mem[address] : 0 (zero added latency; CPU latches at the next edge).
  - read & write same cycle: memoryOut shows pre-write data; new data is visible the following cycle.
  - ld_start=1 in RUN -> LOAD with pointer=0. load_done and cpu_clr change on that edge (cpu_clr=1 from the next cycle).
- Outside RUN:
  - CPU write is dropped.
  - memoryOut=0 regardless of read.
- ld_valid outside LOAD is ignored; no byte is consumed.
- Reset mid-load: memory cleared, partial image discarded, back to IDLE.
- Outputs ld_ready, cpu_clr and load_done are decoded from registered state only (no combinational path from loader inputs).

Decomposition:
- Shared package `program_memory_pkg`:
  - state enum {IDLE, LOAD, RELEASE, RUN}.
  - Constants ADDR_W=4, DATA_W=8, DEPTH=16, also used by CPU.
- One sub-module, `ram_array`:
  - DEPTH x DATA_W register file with async-active-low clear.
  - One synchronous write port (we, waddr, wdata).
  - One combinational read port.
  - Top-level muxes write port between loader (LOAD) and CPU (RUN).

Test Plan:
- Reset -> memoryOut=0, cpu_clr=1, ld_ready=0, load_done=0; every read in a later RUN returns 0x00.
- Short load with early exit:
  - Stimulus: ld_start, then bytes 0xA1, 0x12, 0x3C (last on 0x3C).
  - Required: RELEASE for 1 cycle with cpu_clr=1, then RUN with load_done=1.
  - Reads: addr1 -> 0x12, addr3 -> 0x00.
- Full 16-byte load with ld_valid gaps, bytes 0x00..0x0F, ld_last never asserted:
  - Required: exits after the 16th byte; addr15 reads 0x0F.
  - Required: ld_valid after exit gets ld_ready=0.
- CPU accesses in RUN:
  - write=1, address=5, memoryIn=0x77 -> next-cycle read addr5 = 0x77.
  - Same-cycle read&write at addr5 with data 0x88 -> memoryOut=0x77 that cycle, 0x88 the next.
- CPU write=1 during LOAD -> dropped; memoryOut=0 while read=1 in LOAD.
- Reset and reload:
  - clr low mid-load after 2 bytes -> all words 0, state IDLE.
  - ld_start in RUN -> cpu_clr=1 from the next cycle; reload of 1 byte 0xFF with ld_last overwrites addr0 only; other words retained.

Source files
------------

// File: rtl/program_memory_pkg.sv
// Shared sizing constants and loader/run state encoding for the program memory
// and the CPU that fetches from it.
package program_memory_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN
    } state_e;

endpackage

// File: rtl/program_memory_ram_array.sv
// DEPTH x DATA_W register file: one synchronous write port, one combinational read port.
// Async active-low clear zeroes every word.
module ram_array #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_memory.sv
// Unified CPU program/data memory with a byte-stream loader that fills it while
// the CPU is held in clear; the CPU is released one cycle after the final byte.
module program_memory #(
    parameter int ADDR_W = program_memory_pkg::ADDR_W,
    parameter int DATA_W = program_memory_pkg::DATA_W,
    parameter int DEPTH  = program_memory_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] memoryIn,
    output logic [DATA_W-1:0] memoryOut,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_clr,
    output logic              load_done
);

    import program_memory_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ld_ready_q;
    logic              cpu_clr_q;
    logic              load_done_q;

    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] rdata;

    // ld_ready_q is high exactly in LOAD, so it doubles as the loader accept qualifier.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            ld_ready_q  <= 1'b0;
            cpu_clr_q   <= 1'b1;
            load_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        state_q    <= LOAD;
                        ptr_q      <= '0;
                        ld_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        if (ld_last || ptr_q == LAST_ADDR) begin
                            state_q    <= RELEASE;
                            ld_ready_q <= 1'b0;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    state_q     <= RUN;
                    cpu_clr_q   <= 1'b0;
                    load_done_q <= 1'b1;
                end
                RUN: begin
                    if (ld_start) begin
                        state_q     <= LOAD;
                        ptr_q       <= '0;
                        ld_ready_q  <= 1'b1;
                        cpu_clr_q   <= 1'b1;
                        load_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ld_ready_q  <= 1'b0;
                    cpu_clr_q   <= 1'b1;
                    load_done_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = address;
        wdata_d = memoryIn;
        if (ld_ready_q) begin
            we_d    = ld_valid;
            waddr_d = ptr_q;
            wdata_d = ld_data;
        end else if (load_done_q) begin
            we_d = write;
        end
    end

    ram_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i  (clk),
        .rst_n_i(clr),
        .we_i   (we_d),
        .waddr_i(waddr_d),
        .wdata_i(wdata_d),
        .raddr_i(address),
        .rdata_o(rdata)
    );

    // Read data is the pre-edge array contents, so a same-cycle write shows up next cycle.
    assign memoryOut = (load_done_q && read) ? rdata : '0;
    assign ld_ready  = ld_ready_q;
    assign cpu_clr   = cpu_clr_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory: a session-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_program_memory;

    logic       clk = 1'b0;
    logic       clr;
    logic       read, write;
    logic [3:0] address;
    logic [7:0] memoryIn, memoryOut;
    logic       ld_start, ld_valid, ld_last;
    logic [7:0] ld_data;
    logic       ld_ready, cpu_clr, load_done;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    program_memory dut (
        .clk      (clk),
        .clr      (clr),
        .read     (read),
        .write    (write),
        .address  (address),
        .memoryIn (memoryIn),
        .memoryOut(memoryOut),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .cpu_clr  (cpu_clr),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    // Model: phase 0=idle 1=loading 2=release 3=running
    int         m_phase = 0;
    int         m_ptr   = 0;
    logic [7:0] m_mem [16];

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_phase = 0;
            m_ptr   = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else begin
            case (m_phase)
                0: if (ld_start) begin m_phase = 1; m_ptr = 0; end
                1: if (ld_valid) begin
                       m_mem[m_ptr] = ld_data;
                       if (ld_last || m_ptr == 15) m_phase = 2;
                       else m_ptr = m_ptr + 1;
                   end
                2: m_phase = 3;
                default: begin
                    if (write) m_mem[address] = memoryIn;
                    if (ld_start) begin m_phase = 1; m_ptr = 0; end
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h want %02h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mdl_memoryOut", memoryOut, (m_phase == 3 && read) ? m_mem[address] : 8'h00);
            chk("mdl_ld_ready", {7'b0, ld_ready}, {7'b0, m_phase == 1});
            chk("mdl_cpu_clr", {7'b0, cpu_clr}, {7'b0, m_phase != 3});
            chk("mdl_load_done", {7'b0, load_done}, {7'b0, m_phase == 3});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
        read    = 1'b1;
        address = a;
        #1;
        chk(nm, memoryOut, exp);
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    initial begin
        clr = 1'b0; read = 1'b0; write = 1'b0; address = 4'd3; memoryIn = 8'h00;
        ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        read = 1'b1;
        #1;
        chk("rst_memoryOut", memoryOut, 8'h00);
        chk("rst_cpu_clr", {7'b0, cpu_clr}, 8'h01);
        chk("rst_ld_ready", {7'b0, ld_ready}, 8'h00);
        chk("rst_load_done", {7'b0, load_done}, 8'h00);
        read = 1'b0;
        clr  = 1'b1;
        cmp_en = 1'b1;
        tick();
        chk("idle_ld_ready", {7'b0, ld_ready}, 8'h00);

        // Minimal load of a zero byte, then every word must read zero
        start_load();
        chk("load_ld_ready", {7'b0, ld_ready}, 8'h01);
        send(8'h00, 1'b1);
        chk("rel_cpu_clr", {7'b0, cpu_clr}, 8'h01);
        chk("rel_ld_ready", {7'b0, ld_ready}, 8'h00);
        tick();
        chk("run_load_done", {7'b0, load_done}, 8'h01);
        chk("run_cpu_clr", {7'b0, cpu_clr}, 8'h00);
        for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "rst_zero_rd");
        read = 1'b0;

        // Short load with early exit on ld_last
        start_load();
        send(8'hA1, 1'b0);
        send(8'h12, 1'b0);
        send(8'h3C, 1'b1);
        chk("short_rel_cpu_clr", {7'b0, cpu_clr}, 8'h01);
        chk("short_rel_load_done", {7'b0, load_done}, 8'h00);
        tick();
        chk("short_run_load_done", {7'b0, load_done}, 8'h01);
        rd(4'd1, 8'h12, "short_rd_a1");
        rd(4'd3, 8'h00, "short_rd_a3");
        rd(4'd0, 8'hA1, "short_rd_a0");
        read = 1'b0;

        // Full 16-byte load with valid gaps, no ld_last
        start_load();
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 2) tick();
            send(8'(i), 1'b0);
        end
        ld_valid = 1'b1;
        ld_data  = 8'h55;
        #1;
        chk("full_exit_ld_ready", {7'b0, ld_ready}, 8'h00);
        chk("full_exit_cpu_clr", {7'b0, cpu_clr}, 8'h01);
        tick();
        ld_valid = 1'b0;
        chk("full_run_load_done", {7'b0, load_done}, 8'h01);
        rd(4'd15, 8'h0F, "full_rd_a15");
        rd(4'd0, 8'h00, "full_rd_a0");
        rd(4'd3, 8'h03, "full_rd_a3");
        read = 1'b0;

        // CPU write, then same-cycle read and write
        write = 1'b1; address = 4'd5; memoryIn = 8'h77;
        tick();
        write = 1'b0;
        rd(4'd5, 8'h77, "cpu_wr_rd");
        write = 1'b1; memoryIn = 8'h88;
        #1;
        chk("rw_same_cycle", memoryOut, 8'h77);
        tick();
        write = 1'b0;
        chk("rw_next_cycle", memoryOut, 8'h88);
        read = 1'b0;

        // Reload from RUN: CPU write in LOAD is dropped, reads give zero
        ld_start = 1'b1;
        #1;
        chk("reload_cpu_clr_same", {7'b0, cpu_clr}, 8'h00);
        tick();
        ld_start = 1'b0;
        chk("reload_cpu_clr_next", {7'b0, cpu_clr}, 8'h01);
        chk("reload_load_done", {7'b0, load_done}, 8'h00);
        write = 1'b1; address = 4'd6; memoryIn = 8'hEE; read = 1'b1;
        #1;
        chk("load_rd_zero", memoryOut, 8'h00);
        tick();
        write = 1'b0; read = 1'b0;
        send(8'hFF, 1'b1);
        tick();
        rd(4'd0, 8'hFF, "reload_rd_a0");
        rd(4'd1, 8'h01, "reload_rd_a1");
        rd(4'd6, 8'h06, "reload_rd_a6");
        rd(4'd5, 8'h88, "reload_rd_a5");
        read = 1'b0;

        // Reset in the middle of a load
        start_load();
        send(8'h5A, 1'b0);
        send(8'h6B, 1'b0);
        clr = 1'b0;
        #1;
        chk("midrst_cpu_clr", {7'b0, cpu_clr}, 8'h01);
        chk("midrst_ld_ready", {7'b0, ld_ready}, 8'h00);
        chk("midrst_load_done", {7'b0, load_done}, 8'h00);
        tick();
        clr = 1'b1;
        tick();
        ld_valid = 1'b1; ld_data = 8'h99;
        #1;
        chk("midrst_idle_ld_ready", {7'b0, ld_ready}, 8'h00);
        tick();
        ld_valid = 1'b0;
        start_load();
        send(8'h00, 1'b1);
        tick();
        for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "midrst_zero_rd");
        read = 1'b0;
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
